// File: rtl/cart_mapper_if.sv
// Cartridge bus bundle between the CPU/console side and the bank mapper.
// Carries the CPU address phase, the physical ROM address and both data returns.
// No flow control: every field is qualified only by the CPU phase enable ce.
interface cart_mapper_if #(
    parameter int ROM_AW = 15
);
    logic              ce;
    logic [12:0]       cpu_addr;
    logic              cpu_rwn;
    logic [7:0]        cpu_wdata;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_rdata;
    logic [7:0]        cart_rdata;

    // Console side: drives the CPU cycle and the ROM data, sees the mapped result.
    modport master (
        output ce,
        output cpu_addr,
        output cpu_rwn,
        output cpu_wdata,
        output rom_rdata,
        input  rom_addr,
        input  cart_rdata
    );

    // Mapper side: consumes the CPU cycle, produces the ROM address and cart data.
    modport slave (
        input  ce,
        input  cpu_addr,
        input  cpu_rwn,
        input  cpu_wdata,
        input  rom_rdata,
        output rom_addr,
        output cart_rdata
    );
endinterface

// File: rtl/cart_mapper.sv
// Cartridge bank-switching mapper (2K, 4K, F8, F6, F4, 3F) in front of cartridge ROM.
// Latency: rom_addr/cart_rdata combinational; bank changes take effect the clk after the ce.
// No backpressure; optional Superchip RAM enabled by defining SUPERCHIP_RAM_EN.
module cart_mapper #(
    parameter int ROM_AW   = 15,
    parameter int LAST_SEG = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mapper,
    input  logic        sc_en,
    cart_mapper_if.slave bus,
    output logic [3:0]  bank_dbg
);

    localparam logic [2:0] MAP_2K = 3'd0;
    localparam logic [2:0] MAP_4K = 3'd1;
    localparam logic [2:0] MAP_F8 = 3'd2;
    localparam logic [2:0] MAP_F6 = 3'd3;
    localparam logic [2:0] MAP_F4 = 3'd4;
    localparam logic [2:0] MAP_3F = 3'd5;

    localparam logic [3:0] LAST_SEG_V = 4'(LAST_SEG);

    logic [2:0] mapper_q;
    logic [2:0] bank_q, bank_d;
    logic [3:0] seg0_q, seg0_d;
    logic [2:0] bank_rst;
    logic [3:0] seg;

    // Power-on bank per scheme: banked carts start in their last bank, where the reset vector lives.
    always_comb begin
        bank_rst = 3'd0;
        case (mapper)
            MAP_F8:  bank_rst = 3'd1;
            MAP_F6:  bank_rst = 3'd3;
            MAP_F4:  bank_rst = 3'd7;
            default: bank_rst = 3'd0;
        endcase
    end

    // Next bank/segment from hotspot hits (F8/F6/F4) or low-page writes (3F), only on ce.
    always_comb begin
        bank_d = bank_q;
        seg0_d = seg0_q;
        if (bus.ce) begin
            case (mapper_q)
                MAP_F8: begin
                    if (bus.cpu_addr == 13'h1FF8) begin
                        bank_d = 3'd0;
                    end else if (bus.cpu_addr == 13'h1FF9) begin
                        bank_d = 3'd1;
                    end
                end
                MAP_F6: begin
                    if (bus.cpu_addr >= 13'h1FF6 && bus.cpu_addr <= 13'h1FF9) begin
                        bank_d = 3'(bus.cpu_addr - 13'h1FF6);
                    end
                end
                MAP_F4: begin
                    if (bus.cpu_addr >= 13'h1FF4 && bus.cpu_addr <= 13'h1FFB) begin
                        bank_d = 3'(bus.cpu_addr - 13'h1FF4);
                    end
                end
                MAP_3F: begin
                    // Snooped TIA-space write $0000-$003F selects the switchable 2K segment.
                    if (!bus.cpu_rwn && bus.cpu_addr[12:6] == 7'd0) begin
                        seg0_d = bus.cpu_wdata[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Mapper code is latched only while reset is held; bank state follows next-state logic otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            mapper_q <= mapper;
            bank_q   <= bank_rst;
            seg0_q   <= 4'd0;
        end else begin
            bank_q   <= bank_d;
            seg0_q   <= seg0_d;
        end
    end

    assign seg = bus.cpu_addr[11] ? LAST_SEG_V : seg0_q;

    // Physical ROM address: current cycle uses the registered bank, so a hotspot access reads the old bank.
    always_comb begin
        bus.rom_addr = '0;
        case (mapper_q)
            MAP_2K:  bus.rom_addr = ROM_AW'(bus.cpu_addr[10:0]);
            MAP_F8,
            MAP_F6,
            MAP_F4:  bus.rom_addr = ROM_AW'({bank_q, bus.cpu_addr[11:0]});
            MAP_3F:  bus.rom_addr = ROM_AW'({seg, bus.cpu_addr[10:0]});
            default: bus.rom_addr = ROM_AW'(bus.cpu_addr[11:0]);
        endcase
    end

    // Debug view of the switchable bank register for the active scheme.
    always_comb begin
        bank_dbg = {1'b0, bank_q};
        if (mapper_q == MAP_3F) begin
            bank_dbg = seg0_q;
        end
    end

`ifdef SUPERCHIP_RAM_EN
    logic [7:0] ram_q [0:127];
    logic       sc_active;
    logic       sc_wr_win;
    logic       sc_rd_win;

    assign sc_active = sc_en && (mapper_q == MAP_F8 || mapper_q == MAP_F6 || mapper_q == MAP_F4);
    assign sc_wr_win = sc_active && (bus.cpu_addr[12:7] == 6'b100000);
    assign sc_rd_win = sc_active && (bus.cpu_addr[12:7] == 6'b100001);

    // Superchip RAM write port at $1000-$107F; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && bus.ce && !bus.cpu_rwn && sc_wr_win) begin
            ram_q[bus.cpu_addr[6:0]] <= bus.cpu_wdata;
        end
    end

    // Read port at $1080-$10FF overrides ROM data; the write window still returns ROM.
    always_comb begin
        bus.cart_rdata = bus.rom_rdata;
        if (sc_rd_win) begin
            bus.cart_rdata = ram_q[bus.cpu_addr[6:0]];
        end
    end
`else
    logic [4:0] sc_unused;

    // Without Superchip RAM the cartridge always returns ROM data; sc_en and high write bits are dead.
    always_comb begin
        bus.cart_rdata = bus.rom_rdata;
    end

    assign sc_unused = {sc_en, bus.cpu_wdata[7:4]};
`endif

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper covering every scheme, hotspot timing and Superchip RAM.
// Inputs change 1 time unit after the rising edge and are checked before the next edge.
// ROM is modelled as a combinational function of the physical address.
module tb_cart_mapper;
    logic       clk;
    logic       reset;
    logic [2:0] mapper;
    logic       sc_en;
    logic [3:0] bank_dbg;
    int         checks;
    int         errors;

    cart_mapper_if #(.ROM_AW(15)) bus ();

    cart_mapper #(.ROM_AW(15), .LAST_SEG(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .mapper   (mapper),
        .sc_en    (sc_en),
        .bus      (bus),
        .bank_dbg (bank_dbg)
    );

    function automatic logic [7:0] romf(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    assign bus.rom_rdata = romf(bus.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one CPU cycle with ce, let the edge take it, then drop ce.
    task automatic cpu(input logic [12:0] a, input logic rwn, input logic [7:0] wd);
        bus.cpu_addr  = a;
        bus.cpu_rwn   = rwn;
        bus.cpu_wdata = wd;
        bus.ce        = 1'b1;
        tick();
        bus.ce        = 1'b0;
        bus.cpu_rwn   = 1'b1;
    endtask

    task automatic do_reset(input logic [2:0] m);
        mapper = m;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    task automatic look(input logic [12:0] a);
        bus.cpu_addr = a;
        bus.cpu_rwn  = 1'b1;
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        mapper        = 3'd2;
        sc_en         = 1'b0;
        bus.ce        = 1'b0;
        bus.cpu_addr  = 13'h0000;
        bus.cpu_rwn   = 1'b1;
        bus.cpu_wdata = 8'h00;

        // F8 reset state and hotspot timing
        do_reset(3'd2);
        check("f8_rst_bank", 32'(bank_dbg), 32'h1);
        look(13'h1FFC);
        check("f8_rst_addr", 32'(bus.rom_addr), 32'h1FFC);
        check("f8_rst_data", 32'(bus.cart_rdata), 32'(romf(15'h1FFC)));
        bus.cpu_addr = 13'h1FF8;
        bus.ce       = 1'b1;
        #1;
        check("f8_hot_old_map", 32'(bus.rom_addr), 32'h1FF8);
        tick();
        bus.ce = 1'b0;
        look(13'h1FFC);
        check("f8_new_map", 32'(bus.rom_addr), 32'h0FFC);
        check("f8_bank0", 32'(bank_dbg), 32'h0);
        cpu(13'h1FF9, 1'b1, 8'h00);
        cpu(13'h1FF9, 1'b1, 8'h00);
        check("f8_dummy_idem", 32'(bank_dbg), 32'h1);
        cpu(13'h0FF8, 1'b1, 8'h00);
        check("f8_a12_low_no_hot", 32'(bank_dbg), 32'h1);
        // reset beats a simultaneous hotspot
        bus.cpu_addr = 13'h1FF8;
        bus.ce       = 1'b1;
        reset        = 1'b1;
        tick();
        reset  = 1'b0;
        bus.ce = 1'b0;
        check("f8_reset_wins", 32'(bank_dbg), 32'h1);

        // F4
        do_reset(3'd4);
        check("f4_rst_bank", 32'(bank_dbg), 32'h7);
        cpu(13'h1FFB, 1'b1, 8'h00);
        check("f4_1ffb", 32'(bank_dbg), 32'h7);
        cpu(13'h1FF4, 1'b0, 8'h00);
        check("f4_1ff4_wr", 32'(bank_dbg), 32'h0);
        look(13'h1234);
        check("f4_addr_1234", 32'(bus.rom_addr), 32'h0234);
        cpu(13'h1FF9, 1'b1, 8'h00);
        check("f4_1ff9", 32'(bank_dbg), 32'h5);
        cpu(13'h1FFC, 1'b1, 8'h00);
        check("f4_out_of_range", 32'(bank_dbg), 32'h5);

        // F6 with ce held low
        do_reset(3'd3);
        check("f6_rst_bank", 32'(bank_dbg), 32'h3);
        bus.cpu_addr = 13'h1FF7;
        for (int i = 0; i < 10; i++) tick();
        check("f6_no_ce", 32'(bank_dbg), 32'h3);
        cpu(13'h1FF7, 1'b1, 8'h00);
        check("f6_ce_bank1", 32'(bank_dbg), 32'h1);
        look(13'h1FF7);
        check("f6_addr", 32'(bus.rom_addr), 32'h1FF7);

        // 3F
        do_reset(3'd5);
        check("3f_rst_seg", 32'(bank_dbg), 32'h0);
        look(13'h1123);
        check("3f_rst_addr", 32'(bus.rom_addr), 32'h0123);
        cpu(13'h003F, 1'b0, 8'h0F);
        check("3f_seg_f", 32'(bank_dbg), 32'hF);
        look(13'h1123);
        check("3f_addr_1123", 32'(bus.rom_addr), 32'h7923);
        check("3f_data_1123", 32'(bus.cart_rdata), 32'(romf(15'h7923)));
        look(13'h1923);
        check("3f_last_seg", 32'(bus.rom_addr), 32'h7923);
        cpu(13'h0040, 1'b0, 8'h03);
        check("3f_wr_0040", 32'(bank_dbg), 32'hF);
        cpu(13'h0010, 1'b1, 8'h03);
        check("3f_rd_no_chg", 32'(bank_dbg), 32'hF);
        cpu(13'h0000, 1'b0, 8'hF2);
        look(13'h1123);
        check("3f_seg2_addr", 32'(bus.rom_addr), 32'h1123);

        // mapper frozen outside reset
        do_reset(3'd2);
        mapper = 3'd0;
        tick();
        tick();
        look(13'h1FFF);
        check("map_frozen", 32'(bus.rom_addr), 32'h1FFF);
        do_reset(3'd0);
        look(13'h1FFF);
        check("2k_addr", 32'(bus.rom_addr), 32'h07FF);
        check("2k_bank_dbg", 32'(bank_dbg), 32'h0);
        do_reset(3'd6);
        look(13'h1FFF);
        check("4k_alias6", 32'(bus.rom_addr), 32'h0FFF);

        // Superchip RAM on F8
        sc_en = 1'b1;
        do_reset(3'd2);
        cpu(13'h1005, 1'b0, 8'hA5);
        look(13'h1085);
`ifdef SUPERCHIP_RAM_EN
        check("sc_read", 32'(bus.cart_rdata), 32'hA5);
`else
        check("sc_read_rom", 32'(bus.cart_rdata), 32'(romf(15'h1085)));
`endif
        look(13'h1005);
        check("sc_wrwin_rom", 32'(bus.cart_rdata), 32'(romf(15'h1005)));
        sc_en = 1'b0;
        look(13'h1085);
        check("sc_off_rom", 32'(bus.cart_rdata), 32'(romf(15'h1085)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
